// File: rtl/crc_checker.sv
// Receive-side CRC-8 checker: recomputes the frame CRC and reports pass/fail per frame.
// Latency: last beat accepted at edge N, frame_done pulses in the cycle after edge N+1.
// Backpressure: in_ready is low for exactly one cycle per frame (report bubble), else high.
module crc_checker #(
  parameter int CRC_LENGTH = 8,
  parameter int MAX_FRAME  = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CRC_LENGTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic [CRC_LENGTH-1:0] generator,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic                  frame_len_err,
  output logic [CRC_LENGTH-1:0] crc_value,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam int LW = $clog2(MAX_FRAME + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP, REPORT} state_t;

  state_t                state_q, state_d;
  logic [CRC_LENGTH-1:0] crc_q, crc_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  // Frame result captured on the last beat, published one cycle later.
  logic                  pend_zero_q, pend_zero_d;
  logic                  pend_len_err_q, pend_len_err_d;
  logic [CRC_LENGTH-1:0] pend_crc_q, pend_crc_d;
  logic [CRC_LENGTH-1:0] step;
  logic                  accept;

  // One byte of MSB-first CRC: xor in the data, then shift out CRC_LENGTH bits.
  function automatic logic [CRC_LENGTH-1:0] crc_step(input logic [CRC_LENGTH-1:0] c,
                                                     input logic [CRC_LENGTH-1:0] d,
                                                     input logic [CRC_LENGTH-1:0] g);
    logic [CRC_LENGTH-1:0] r;
    r = c ^ d;
    for (int i = 0; i < CRC_LENGTH; i++) begin
      r = r[CRC_LENGTH-1] ? ((r << 1) ^ g) : (r << 1);
    end
    return r;
  endfunction

  assign in_ready = (state_q != REPORT);
  assign accept   = in_valid && in_ready;

  // Next-state, CRC accumulation, beat counting and result capture.
  always_comb begin
    state_d        = state_q;
    crc_d          = crc_q;
    cnt_d          = cnt_q;
    pend_zero_d    = pend_zero_q;
    pend_len_err_d = pend_len_err_q;
    pend_crc_d     = pend_crc_q;
    step           = crc_step(crc_q, in_data, generator);
    case (state_q)
      IDLE: begin
        if (accept) begin
          crc_d = step;
          cnt_d = LW'(1);
          if (in_last) begin
            // A lone CRC beat has no payload: always a length error.
            state_d        = REPORT;
            pend_zero_d    = (step == '0);
            pend_len_err_d = 1'b1;
            pend_crc_d     = crc_q;
          end else begin
            state_d = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        if (accept) begin
          crc_d = step;
          cnt_d = cnt_q + 1'b1;
          if (in_last) begin
            state_d        = REPORT;
            pend_zero_d    = (step == '0);
            pend_len_err_d = 1'b0;
            pend_crc_d     = crc_q;
          end else if (cnt_q == LW'(MAX_FRAME - 1)) begin
            // MAX_FRAME beats taken and still no last: frame is too long.
            state_d = DROP;
          end
        end
      end
      DROP: begin
        // Swallow the oversize tail; CRC register is frozen.
        if (accept && in_last) begin
          state_d        = REPORT;
          pend_zero_d    = 1'b0;
          pend_len_err_d = 1'b1;
          pend_crc_d     = crc_q;
        end
      end
      REPORT: begin
        state_d = IDLE;
        crc_d   = '0;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, CRC and captured-result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      crc_q          <= '0;
      cnt_q          <= '0;
      pend_zero_q    <= 1'b0;
      pend_len_err_q <= 1'b0;
      pend_crc_q     <= '0;
    end else begin
      state_q        <= state_d;
      crc_q          <= crc_d;
      cnt_q          <= cnt_d;
      pend_zero_q    <= pend_zero_d;
      pend_len_err_q <= pend_len_err_d;
      pend_crc_q     <= pend_crc_d;
    end
  end

  // Publish results while leaving REPORT; fields hold until the next frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done    <= 1'b0;
      frame_ok      <= 1'b0;
      frame_len_err <= 1'b0;
      crc_value     <= '0;
      err_count     <= '0;
    end else begin
      frame_done <= (state_q == REPORT);
      if (state_q == REPORT) begin
        frame_ok      <= pend_zero_q && !pend_len_err_q;
        frame_len_err <= pend_len_err_q;
        crc_value     <= pend_crc_q;
        if (!(pend_zero_q && !pend_len_err_q) && (err_count != '1)) begin
          err_count <= err_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_checker.sv
module tb_crc_checker;

  localparam int MAXF = 64;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [7:0]    generator = 8'h07;
  logic          frame_done;
  logic          frame_ok;
  logic          frame_len_err;
  logic [7:0]    crc_value;
  logic [CW-1:0] err_count;

  crc_checker #(.CRC_LENGTH(8), .MAX_FRAME(MAXF), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .generator(generator),
    .frame_done(frame_done), .frame_ok(frame_ok), .frame_len_err(frame_len_err),
    .crc_value(crc_value), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    bit         ok;
    bit         len_err;
    logic [7:0] crc;
  } exp_t;

  exp_t          exp_q[$];
  logic [7:0]    cur[$];
  logic [7:0]    msg[$];
  int            last_acc = -10;
  bit            h_ok = 0;
  bit            h_len = 0;
  logic [7:0]    h_crc = '0;
  logic [CW-1:0] h_err = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Bit-serial LFSR view of the CRC: long division of the message by x^8+gen.
  function automatic logic [7:0] model_crc(input int n);
    logic [7:0] c;
    logic       fb;
    c = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 7; j >= 0; j--) begin
        fb = c[7] ^ msg[i][j];
        c  = {c[6:0], 1'b0} ^ (fb ? generator : 8'h00);
      end
    end
    return c;
  endfunction

  // Model of one complete frame, evaluated once the whole frame is known.
  task automatic close_frame();
    exp_t e;
    int   len;
    len       = cur.size();
    msg       = cur;
    e.cyc     = cyc + 1;
    e.len_err = (len < 2) || (len > MAXF);
    e.crc     = e.len_err ? 8'h00 : model_crc(len - 1);
    e.ok      = !e.len_err && (model_crc(len) == 8'h00);
    exp_q.push_back(e);
    cur.delete();
  endtask

  task automatic send(input logic [7:0] d, input bit last);
    bit done;
    done     = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 10 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
        cur.push_back(d);
        if (last) begin
          last_acc = cyc;
          close_frame();
        end
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 10 cycles");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b0;
    cur.delete();
    exp_q.delete();
    h_ok = 0; h_len = 0; h_crc = '0; h_err = '0;
    last_acc = -10;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Send a frame: payload bytes followed by a CRC beat (model CRC xor flip).
  task automatic send_frame(input logic [7:0] pay[$], input logic [7:0] flip);
    logic [7:0] c;
    msg = pay;
    c   = model_crc(pay.size()) ^ flip;
    foreach (pay[i]) send(pay[i], 1'b0);
    send(c, 1'b1);
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    exp_t e;
    bit   due;
    forever begin
      @(negedge clk);
      due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (due) begin
        e     = exp_q.pop_front();
        h_ok  = e.ok;
        h_len = e.len_err;
        h_crc = e.crc;
        if (!e.ok && h_err != '1) h_err = h_err + 1'b1;
      end
      check("frame_done", frame_done, due);
      check("in_ready", in_ready, (cyc == last_acc) ? 0 : 1);
      check("frame_ok", frame_ok, h_ok);
      check("frame_len_err", frame_len_err, h_len);
      if (!h_len) check("crc_value", crc_value, h_crc);
      check("err_count", err_count, h_err);
    end
  end

  initial begin
    logic [7:0] p[$];
    #1;
    do_reset();

    // Pin the model against known CRC-8 (poly 0x07) results.
    msg = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("model_check_string", model_crc(9), 8'hF4);
    msg = {8'h01};
    check("model_single_01", model_crc(1), 8'h07);

    // "123456789" + F4
    foreach (msg[i]) ;
    p = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    foreach (p[i]) send(p[i], 1'b0);
    send(8'hF4, 1'b1);
    idle(3);
    check("lit_ok_123456789", frame_ok, 1);
    check("lit_crc_123456789", crc_value, 8'hF4);
    check("lit_err_123456789", err_count, 0);

    send(8'h01, 1'b0); send(8'h07, 1'b1);
    idle(3);
    check("lit_ok_01_07", frame_ok, 1);
    check("lit_crc_01_07", crc_value, 8'h07);

    send(8'h01, 1'b0); send(8'h08, 1'b1);
    idle(3);
    check("lit_ok_01_08", frame_ok, 0);
    check("lit_len_01_08", frame_len_err, 0);
    check("lit_err_01_08", err_count, 1);

    send(8'h55, 1'b1);
    idle(3);
    check("lit_len_single", frame_len_err, 1);
    check("lit_err_single", err_count, 2);

    // 65 beats: oversize frame ends in DROP
    for (int i = 1; i <= 65; i++) send(8'(i), i == 65);
    idle(3);
    check("lit_len_65", frame_len_err, 1);
    check("lit_err_65", err_count, 3);

    // Exactly MAX_FRAME beats is legal
    p.delete();
    for (int i = 0; i < MAXF - 1; i++) p.push_back(8'(i * 7 + 3));
    send_frame(p, 8'h00);
    idle(3);
    check("lit_ok_64", frame_ok, 1);

    // Different polynomial
    generator = 8'h1D;
    p = {8'hA5, 8'h3C, 8'hFF};
    send_frame(p, 8'h00);
    idle(3);
    generator = 8'h07;

    // Reset after the third beat of a frame
    send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0);
    do_reset();
    idle(3);
    check("lit_err_after_reset", err_count, 0);
    send(8'h01, 1'b0); send(8'h07, 1'b1);
    idle(3);
    check("lit_ok_after_reset", frame_ok, 1);

    // Back-to-back frames with in_valid held high
    p = {8'h11, 8'h22};
    send_frame(p, 8'h00);
    p = {8'h33};
    send_frame(p, 8'h01);
    p = {8'h44, 8'h55, 8'h66};
    send_frame(p, 8'h00);
    send(8'h01, 1'b0); send(8'h07, 1'b1);
    idle(4);

    // Drive the counter into saturation
    for (int k = 0; k < 8; k++) begin
      send(8'h01, 1'b0); send(8'h08, 1'b1);
    end
    idle(4);
    check("lit_err_saturated", err_count, 3'h7);

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    check("pending_results", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
